// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: fetch states, opcode constants, word helpers
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SKID = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Named OP_HALT so it cannot collide with the HALT state literal above.
    localparam opcode_t OP_HALT = 6'h3F;

    function automatic logic is_halt(input word_t w);
        return w[31:26] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch stage signal bundle, used next to pc_if at the integration level
interface fetch_if;
    import cpu_types_pkg::*;

    word_t imemaddr;
    word_t pc_plus_4;
    word_t imemload;
    logic  ihit;
    logic  stall;
    logic  flush;
    logic  imemREN;
    word_t imemaddr_o;
    logic  pc_en;
    word_t instr;
    word_t npc;
    logic  valid;
    logic  halted;

    modport fetch (
        input  imemaddr, pc_plus_4, imemload, ihit, stall, flush,
        output imemREN, imemaddr_o, pc_en, instr, npc, valid, halted
    );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID payload register {instr, npc, valid} with load/clear/drop controls
module if_id_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  i_clear,
    input  logic  i_load,
    input  logic  i_drop,
    input  word_t i_instr,
    input  word_t i_npc,
    output word_t o_instr,
    output word_t o_npc,
    output logic  o_valid
);

    word_t r_instr;
    word_t r_npc;
    logic  r_valid;

    // clear beats load beats drop; drop only kills valid so instr/npc hold on a bubble
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instr <= '0;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_instr <= '0;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_npc   <= i_npc;
            r_valid <= 1'b1;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_npc   = r_npc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with one-entry skid buffer and HALT detection
module fetch_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] imemaddr,
    input  logic [31:0] pc_plus_4,
    input  logic [31:0] imemload,
    input  logic        ihit,
    input  logic        stall,
    input  logic        flush,
    output logic        imemREN,
    output logic [31:0] imemaddr_o,
    output logic        pc_en,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic        valid,
    output logic        halted
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    word_t r_skid_instr;
    word_t r_skid_npc;

    logic  w_pc_en;
    logic  w_load;
    logic  w_clear;
    logic  w_drop;
    logic  w_skid_wr;
    logic  w_sel_skid;
    word_t w_load_instr;
    word_t w_load_npc;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // flush outranks stall and every state; it also gives the PC its redirect load
    always_comb begin
        w_next_state = r_state;
        w_pc_en      = 1'b0;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_drop       = 1'b0;
        w_skid_wr    = 1'b0;
        w_sel_skid   = 1'b0;
        if (flush) begin
            w_clear      = 1'b1;
            w_pc_en      = 1'b1;
            w_next_state = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (ihit) begin
                        w_pc_en = 1'b1;
                        if (!stall) begin
                            w_load = 1'b1;
                            if (is_halt(imemload)) begin
                                w_next_state = HALT;
                            end
                        end else begin
                            w_skid_wr    = 1'b1;
                            w_next_state = SKID;
                        end
                    end else if (!stall) begin
                        w_drop = 1'b1;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        w_load       = 1'b1;
                        w_sel_skid   = 1'b1;
                        w_next_state = is_halt(r_skid_instr) ? HALT : RUN;
                    end
                end
                HALT: begin
                    if (!stall) begin
                        w_drop = 1'b1;
                    end
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_skid_instr <= '0;
            r_skid_npc   <= '0;
        end else if (flush) begin
            r_skid_instr <= '0;
            r_skid_npc   <= '0;
        end else if (w_skid_wr) begin
            r_skid_instr <= imemload;
            r_skid_npc   <= pc_plus_4;
        end
    end

    assign w_load_instr = w_sel_skid ? r_skid_instr : imemload;
    assign w_load_npc   = w_sel_skid ? r_skid_npc   : pc_plus_4;

    if_id_reg u_if_id_reg (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_drop  (w_drop),
        .i_instr (w_load_instr),
        .i_npc   (w_load_npc),
        .o_instr (instr),
        .o_npc   (npc),
        .o_valid (valid)
    );

    assign imemREN    = nRST && (r_state == RUN);
    assign pc_en      = nRST && w_pc_en;
    assign halted     = (r_state == HALT);
    assign imemaddr_o = imemaddr;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed plus random bench for fetch_stage against a behavioural model
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] imemaddr;
    logic [31:0] pc_plus_4;
    logic [31:0] imemload;
    logic        ihit;
    logic        stall;
    logic        flush;
    logic        imemREN;
    logic [31:0] imemaddr_o;
    logic        pc_en;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic        halted;

    always #5 CLK = ~CLK;

    fetch_stage dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemaddr   (imemaddr),
        .pc_plus_4  (pc_plus_4),
        .imemload   (imemload),
        .ihit       (ihit),
        .stall      (stall),
        .flush      (flush),
        .imemREN    (imemREN),
        .imemaddr_o (imemaddr_o),
        .pc_en      (pc_en),
        .instr      (instr),
        .npc        (npc),
        .valid      (valid),
        .halted     (halted)
    );

    int total = 0;
    int bad   = 0;

    // reference: IF/ID contents, a parked-word queue (at most one entry) and a halted flag
    logic [31:0] m_instr;
    logic [31:0] m_npc;
    logic        m_valid;
    logic        m_halted;
    logic [63:0] m_skid[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_instr  = '0;
        m_npc    = '0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_skid.delete();
    endtask

    // one clock: drive, check combinational outputs, clock, advance model, check registers
    task automatic step(input logic h, input logic s, input logic f,
                        input logic [31:0] word, input logic [31:0] addr);
        logic fetching;
        logic [63:0] parked;
        ihit      = h;
        stall     = s;
        flush     = f;
        imemload  = word;
        imemaddr  = addr;
        pc_plus_4 = addr + 32'd4;
        fetching  = !m_halted && (m_skid.size() == 0);
        #1;
        chk1("pc_en", pc_en, f || (fetching && h));
        chk1("imemREN", imemREN, fetching);
        chk("imemaddr_o", imemaddr_o, addr);
        @(posedge CLK);
        if (f) begin
            m_instr  = '0;
            m_npc    = '0;
            m_valid  = 1'b0;
            m_halted = 1'b0;
            m_skid.delete();
        end else if (m_halted) begin
            if (!s) m_valid = 1'b0;
        end else if (m_skid.size() != 0) begin
            if (!s) begin
                parked  = m_skid.pop_front();
                m_instr = parked[63:32];
                m_npc   = parked[31:0];
                m_valid = 1'b1;
                if (m_instr[31:26] == 6'h3F) m_halted = 1'b1;
            end
        end else if (h) begin
            if (s) begin
                m_skid.push_back({word, addr + 32'd4});
            end else begin
                m_instr = word;
                m_npc   = addr + 32'd4;
                m_valid = 1'b1;
                if (word[31:26] == 6'h3F) m_halted = 1'b1;
            end
        end else if (!s) begin
            m_valid = 1'b0;
        end
        #1;
        chk("instr", instr, m_instr);
        chk("npc", npc, m_npc);
        chk1("valid", valid, m_valid);
        chk1("halted", halted, m_halted);
    endtask

    initial begin
        nRST      = 1'b0;
        ihit      = 1'b1;
        stall     = 1'b0;
        flush     = 1'b1;
        imemload  = 32'h1234_5678;
        imemaddr  = 32'h0;
        pc_plus_4 = 32'h4;
        model_reset();
        @(posedge CLK);
        #1;
        chk("rst_instr", instr, 32'h0);
        chk("rst_npc", npc, 32'h0);
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_pc_en", pc_en, 1'b0);
        chk1("rst_imemREN", imemREN, 1'b0);
        nRST = 1'b1;

        // streaming
        step(1, 0, 0, 32'h8C22_0004, 32'h0000_0000);
        chk("stream_instr", instr, 32'h8C22_0004);
        chk("stream_npc", npc, 32'h0000_0004);
        step(1, 0, 0, 32'h2001_0005, 32'h0000_0004);

        // skid then release
        step(1, 1, 0, 32'h0022_1820, 32'h0000_0008);
        chk("skid_hold_instr", instr, 32'h2001_0005);
        step(0, 0, 0, 32'hDEAD_BEEF, 32'h0000_000C);
        chk("skid_out_instr", instr, 32'h0022_1820);

        // flush while parked and stalled
        step(1, 1, 0, 32'h1111_1111, 32'h0000_000C);
        step(0, 1, 0, 32'h0, 32'h0000_0010);
        step(1, 1, 1, 32'h2222_2222, 32'h0000_0010);
        chk("flush_instr", instr, 32'h0);
        chk1("flush_valid", valid, 1'b0);
        step(1, 0, 0, 32'h3333_3333, 32'h0000_0040);

        // misses
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 32'h0000_0044);
        chk("miss_instr_hold", instr, 32'h3333_3333);

        // halt, held under stall, then dropped and frozen
        step(1, 0, 0, 32'hFFFF_FFFF, 32'h0000_0044);
        chk1("halt_flag", halted, 1'b1);
        step(1, 1, 0, 32'h4444_4444, 32'h0000_0048);
        for (int i = 0; i < 10; i++) step(1, 0, 0, $urandom, 32'h0000_0048);
        chk("halt_instr", instr, 32'hFFFF_FFFF);
        step(1, 0, 1, 32'h5555_5555, 32'h0000_0100);

        // halt word parked in skid only halts once transferred
        step(1, 1, 0, 32'hFC00_0000, 32'h0000_0100);
        chk1("halt_parked", halted, 1'b0);
        step(1, 0, 0, 32'h0, 32'h0000_0104);
        step(1, 0, 1, 32'h0, 32'h0000_0200);

        // asynchronous reset mid-skid
        step(1, 1, 0, 32'h0022_1820, 32'h0000_0200);
        #2;
        flush = 1'b1;
        ihit  = 1'b1;
        nRST  = 1'b0;
        #1;
        model_reset();
        chk("arst_instr", instr, 32'h0);
        chk("arst_npc", npc, 32'h0);
        chk1("arst_valid", valid, 1'b0);
        chk1("arst_pc_en", pc_en, 1'b0);
        chk1("arst_imemREN", imemREN, 1'b0);
        #1;
        nRST  = 1'b1;
        flush = 1'b0;
        ihit  = 1'b0;
        @(posedge CLK);
        #1;
        chk1("post_rst_imemREN", imemREN, 1'b1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 15) == 0) w[31:26] = 6'h3F;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 11) == 0, w, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
